// File: rtl/reg_file.sv
// reg_file: 32 x n-bit register file, two combinational read ports, one write
// port, with optional same-cycle write-to-read forwarding.
//
// Ports:
//   clk            rising-edge clock for all state
//   rst_n          synchronous active-low reset, clears x1..x31
//   rs1, rs2       read indices (5 bits each)
//   rdata1, rdata2 read data (n bits), combinational from the indices
//   we, rd, wdata  write enable, write index, write data
//
// x0 is hard-wired to zero. While rst_n is low, both read ports return zero
// and forwarding is suppressed. This keeps pre-reset storage contents from
// leaking out on the read ports.
module reg_file #(
  parameter int n      = 32,
  parameter int BYPASS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [4:0]   rs1,
  input  logic [4:0]   rs2,
  output logic [n-1:0] rdata1,
  output logic [n-1:0] rdata2,
  input  logic         we,
  input  logic [4:0]   rd,
  input  logic [n-1:0] wdata
);

  logic [31:0][n-1:0] r_x;
  logic [31:0]        w_wsel;
  logic               w_fwd1, w_fwd2;

  // One-hot write select; line 0 is tied low so x0 can never be written.
  assign w_wsel[0] = 1'b0;
  for (genvar k = 1; k < 32; k++) begin : g_dec
    assign w_wsel[k] = we && (rd == 5'(k));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x <= '0;
    end else begin
      for (int k = 1; k < 32; k++)
        if (w_wsel[k]) r_x[k] <= wdata;
    end
  end

  // Forwarding is only meaningful for a live, non-x0 write.
  assign w_fwd1 = (BYPASS != 0) && we && (rd != 5'd0) && (rs1 == rd);
  assign w_fwd2 = (BYPASS != 0) && we && (rd != 5'd0) && (rs2 == rd);

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (rst_n) begin
      if (w_fwd1)              rdata1 = wdata;
      else if (rs1 != 5'd0)    rdata1 = r_x[rs1];
      if (w_fwd2)              rdata2 = wdata;
      else if (rs2 != 5'd0)    rdata2 = r_x[rs2];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1, rs2, rd;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] b_rd1, b_rd2, nb_rd1, nb_rd2;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // Reference: what is architecturally stored (updated at each edge).
  logic [31:0] mem [32];

  reg_file #(.n(32), .BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2),
    .rdata1(b_rd1), .rdata2(b_rd2), .we(we), .rd(rd), .wdata(wdata));

  reg_file #(.n(32), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2),
    .rdata1(nb_rd1), .rdata2(nb_rd2), .we(we), .rd(rd), .wdata(wdata));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial for (int i = 0; i < 32; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (we && rd != 5'd0) begin
      mem[rd] <= wdata;
    end
  end

  function automatic logic [31:0] expect_rd(input bit byp, input logic [4:0] rs);
    if (!rst_n)                              return '0;
    if (rs == 5'd0)                          return '0;
    if (byp && we && rd != 5'd0 && rs == rd) return wdata;
    return mem[rs];
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t rs1=%0d rs2=%0d we=%0b rd=%0d rst_n=%0b)",
               name, act, exp, $time, rs1, rs2, we, rd, rst_n);
    end
  endtask

  // Every cycle: both DUT flavours against the model, away from the edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("byp_rdata1",   b_rd1,  expect_rd(1'b1, rs1));
      cmp("byp_rdata2",   b_rd2,  expect_rd(1'b1, rs2));
      cmp("nobyp_rdata1", nb_rd1, expect_rd(1'b0, rs1));
      cmp("nobyp_rdata2", nb_rd2, expect_rd(1'b0, rs2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setin(input logic r, input logic w, input logic [4:0] d,
                       input logic [31:0] wd, input logic [4:0] a, input logic [4:0] b);
    rst_n = r; we = w; rd = d; wdata = wd; rs1 = a; rs2 = b;
    #1;
  endtask

  initial begin
    setin(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    chk_en = 1;

    // Reset for two edges, then sweep all indices.
    tick(); tick();
    for (int k = 0; k < 32; k++) begin
      setin(1'b1, 1'b0, 5'd0, 32'h0, 5'(k), 5'(31 - k));
      cmp("reset_sweep1", b_rd1, 32'h0);
      cmp("reset_sweep2", nb_rd2, 32'h0);
      tick();
    end

    // Basic write/read.
    setin(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    tick();
    setin(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    cmp("basic_rd1", b_rd1, 32'hDEADBEEF);
    cmp("basic_rd2", b_rd2, 32'h0);
    cmp("basic_nb_rd1", nb_rd1, 32'hDEADBEEF);
    tick();

    // x0 protection.
    setin(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    cmp("x0_fwd", b_rd1, 32'h0);
    tick();
    setin(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5);
    cmp("x0_read", b_rd1, 32'h0);
    cmp("x0_other", b_rd2, 32'hDEADBEEF);
    tick();

    // Same-cycle forwarding vs. pre-write value.
    setin(1'b1, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7);
    cmp("byp_p1", b_rd1, 32'h12345678);
    cmp("byp_p2", b_rd2, 32'h12345678);
    cmp("nobyp_old1", nb_rd1, 32'h0);
    cmp("nobyp_old2", nb_rd2, 32'h0);
    tick();
    setin(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    cmp("nobyp_new", nb_rd1, 32'h12345678);
    tick();

    // Reset priority over a simultaneous write; forwarding suppressed in reset.
    setin(1'b0, 1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd5);
    cmp("rst_nofwd", b_rd1, 32'h0);
    cmp("rst_gate", b_rd2, 32'h0);
    tick();
    setin(1'b1, 1'b0, 5'd0, 32'h0, 5'd31, 5'd5);
    cmp("rst_prio_x31", b_rd1, 32'h0);
    cmp("rst_cleared_x5", b_rd2, 32'h0);
    tick();

    // Full sweep: x[k] = k * 0x01010101.
    for (int k = 1; k < 32; k++) begin
      setin(1'b1, 1'b1, 5'(k), 32'(k) * 32'h01010101, 5'd0, 5'd0);
      tick();
    end
    for (int k = 0; k < 32; k++) begin
      setin(1'b1, 1'b0, 5'd0, 32'h0, 5'(k), 5'((32 - k) % 32));
      cmp("sweep_p1", b_rd1, 32'(k) * 32'h01010101);
      cmp("sweep_p2", nb_rd2, 32'((32 - k) % 32) * 32'h01010101);
      tick();
    end

    // Randomized traffic with occasional mid-sequence resets.
    for (int i = 0; i < 600; i++) begin
      setin(($urandom_range(0, 39) != 0), 1'($urandom), 5'($urandom),
            $urandom, 5'($urandom), 5'($urandom));
      if ($urandom_range(0, 5) == 0) rs2 = rs1;
      if ($urandom_range(0, 3) == 0) rs1 = rd;
      tick();
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter n, default 32, giving the data width of each register and of each read/write port.
REQ-002 SHALL have parameter BYPASS, default 1, which enables same-cycle write-to-read forwarding when 1.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, a synchronous, active-low reset sampled on the rising edge of clk.
REQ-005 SHALL have port rs1, input, 5, the read-port-1 register index.
REQ-006 SHALL have port rs2, input, 5, the read-port-2 register index.
REQ-007 SHALL have port rdata1, output, n, the read-port-1 data.
REQ-008 SHALL have port rdata2, output, n, the read-port-2 data.
REQ-009 SHALL have port we, input, 1, the write enable.
REQ-010 SHALL have port rd, input, 5, the write register index.
REQ-011 SHALL have port wdata, input, n, the write data.

Function
REQ-012 SHALL hold 32 registers x0..x31, each n bits wide.
REQ-013 SHALL drive the write path through a 5-to-32 one-hot write-select decoder (demux): select line k = we AND (rd == k) AND (k != 0).
REQ-014 SHALL write wdata into register rd on the rising clk edge when the select line for rd is high and rst_n = 1; all other registers hold.
REQ-015 SHALL never store into x0; x0 reads 0 at all times, regardless of we, rd or wdata.
REQ-016 SHALL produce read data combinationally from the indices: rdata1 = x[rs1] and rdata2 = x[rs2], with zero-cycle latency from an index change.
REQ-017 SHALL, when BYPASS = 1, we = 1, rd != 0 and rsN == rd, drive rdataN = wdata in the same cycle, for both ports independently.
REQ-018 SHALL, when BYPASS = 0, return the pre-write value on a same-cycle read of rd; the new value becomes visible in the cycle after the edge.
REQ-019 SHALL allow rs1 == rs2 with both ports returning identical data, including under bypass.
REQ-020 SHALL update x31 on a write to rd = 31 without affecting x0 or any other register (no index wrap-around).
REQ-021 SHALL never let rdata1 or rdata2 be X after reset; every register has a defined value.
REQ-022 SHALL contain no latches and a single always block clocked by clk.

Reset
REQ-023 SHALL, on a rising clk edge with rst_n = 0, clear x1..x31 to 0 in that same edge.
REQ-024 SHALL give reset priority over a simultaneous write: with rst_n = 0 and we = 1, the target register becomes 0.
REQ-025 SHALL drive rdata1 = rdata2 = 0 for any rs1/rs2 during and after reset, until the first write, with bypass suppressed while rst_n = 0.
REQ-026 SHALL keep the registers cleared when reset is asserted mid-sequence, between writes, with no partial state surviving.

Verification
REQ-027 Reset: assert rst_n = 0 for 2 edges, then sweep rs1/rs2 over 0..31 -> all reads 0.
REQ-028 Basic write/read: write x5 = 0xDEADBEEF (we = 1, rd = 5), next cycle set rs1 = 5, rs2 = 0 -> rdata1 = 0xDEADBEEF, rdata2 = 0.
REQ-029 x0 protection: write rd = 0 with wdata = 0xFFFFFFFF -> rs1 = 0 reads 0; no other register changed.
REQ-030 Bypass: with BYPASS = 1, set we = 1, rd = 7, wdata = 0x12345678, rs1 = rs2 = 7 in the same cycle -> both ports read 0x12345678 before the edge. With BYPASS = 0, the ports read the old value (0) before the edge and 0x12345678 after it.
REQ-031 Reset priority: rst_n = 0 with we = 1, rd = 31, wdata = 0xA5A5A5A5 -> x31 reads 0 after the edge.
REQ-032 Full sweep: write x[k] = k*0x01010101 for k = 1..31, then read all pairs (k, 32-k) -> expected values on both ports; x0 = 0.
